// File: rtl/issue_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : issue_hazard_ctrl
//  Brief    : Decode-stage issue controller. Keeps a per-register latency
//             scoreboard for long-latency writebacks (load, ftoi, multiply),
//             sequences the shared multiplier and produces stall/issue for
//             the instruction sitting in ID.
//  Options  : ISSUE_MUL_PIPELINED_EN - multiplier accepts one op per cycle
//             (no structural hazard, mul_busy tied low).
//  Revision : 1.0 - initial release
// ============================================================================
module issue_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_reg_write,
  input  logic        id_is_hazard_0,
  input  logic        id_is_multiply,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic [31:0] pending,
  output logic        mul_busy
);

  localparam logic [2:0] LOAD_LAT_C = 3'(LOAD_LAT);
  localparam logic [2:0] MUL_LAT_C  = 3'(MUL_LAT);

  // Flat read view of the scoreboard; entry 0 is the hard-wired x0 slot.
  logic [2:0] cnt_view [32];
  logic [2:0] lat;
  logic       raw_haz;
  logic       waw_haz;
  logic       struct_haz;
  logic       set_en;

  // Hazard detection and the stall/issue decision for the ID instruction.
  always_comb begin
    lat     = id_is_multiply ? MUL_LAT_C : LOAD_LAT_C;
    raw_haz = (id_use_rs1 && (id_rs1 != 5'd0) && (cnt_view[id_rs1] != 3'd0)) ||
              (id_use_rs2 && (id_rs2 != 5'd0) && (cnt_view[id_rs2] != 3'd0));
    // A long-latency writer may follow an older one as long as it cannot
    // complete first; a single-cycle writer must wait for it to drain fully.
    waw_haz = id_reg_write && (id_rd != 5'd0) &&
              (cnt_view[id_rd] > (id_is_hazard_0 ? lat : 3'd0));
    stall   = id_valid && !flush && (raw_haz || waw_haz || struct_haz || !ex_ready);
    issue   = id_valid && !flush && !stall;
    set_en  = issue && id_reg_write && id_is_hazard_0 && (id_rd != 5'd0);
  end

  for (genvar r = 0; r < 32; r++) begin : g_reg
    if (r == 0) begin : g_x0
      assign cnt_view[r] = 3'd0;
      assign pending[r]  = 1'b0;
    end else begin : g_cnt
      logic [2:0] cnt_d;
      logic [2:0] cnt_q;

      // Count down while the pipeline advances; a new issue to this rd reloads.
      always_comb begin
        cnt_d = cnt_q;
        if (ex_ready && (cnt_q != 3'd0)) begin
          cnt_d = cnt_q - 3'd1;
        end
        if (set_en && (id_rd == 5'(r))) begin
          cnt_d = lat;
        end
      end

      // Per-register latency counter.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_q <= 3'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_view[r] = cnt_q;
      assign pending[r]  = (cnt_q != 3'd0);
    end
  end

`ifdef ISSUE_MUL_PIPELINED_EN
  assign struct_haz = 1'b0;
  assign mul_busy   = 1'b0;
`else
  logic [2:0] mul_cnt_d;
  logic [2:0] mul_cnt_q;

  // Multiplier occupancy: reload on multiply issue, drain while not frozen.
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (ex_ready && (mul_cnt_q != 3'd0)) begin
      mul_cnt_d = mul_cnt_q - 3'd1;
    end
    if (issue && id_is_multiply) begin
      mul_cnt_d = MUL_LAT_C;
    end
  end

  // Multiplier occupancy counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_cnt_q <= 3'd0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign struct_haz = id_is_multiply && (mul_cnt_q != 3'd0);
  assign mul_busy   = (mul_cnt_q != 3'd0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_hazard_ctrl
//  Brief    : Self-checking bench for issue_hazard_ctrl (LOAD_LAT=1,
//             MUL_LAT=3). Expected results are queued as stimulus is driven
//             and popped when the DUT outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_hazard_ctrl;

  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write;
  logic        id_is_hazard_0, id_is_multiply, ex_ready, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, issue, mul_busy;
  logic [31:0] pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1, u2, rw, haz, mul, rdy, fl;
  } in_t;

  typedef struct {
    logic        stall;
    logic        issue;
    logic [31:0] pend;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  issue_hazard_ctrl #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write),
    .id_is_hazard_0(id_is_hazard_0), .id_is_multiply(id_is_multiply),
    .ex_ready(ex_ready), .flush(flush),
    .stall(stall), .issue(issue), .pending(pending), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic in_t f_nop();
    in_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic in_t f_alu(input int rd, input int rs1, input int rs2);
    in_t s;
    s = f_nop();
    s.valid = 1'b1; s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.u1 = 1'b1; s.u2 = 1'b1; s.rw = 1'b1;
    return s;
  endfunction

  function automatic in_t f_ld(input int rd, input int rs1);
    in_t s;
    s = f_nop();
    s.valid = 1'b1; s.rd = 5'(rd); s.rs1 = 5'(rs1);
    s.u1 = 1'b1; s.rw = 1'b1; s.haz = 1'b1;
    return s;
  endfunction

  function automatic in_t f_mul(input int rd, input int rs1, input int rs2);
    in_t s;
    s = f_alu(rd, rs1, rs2);
    s.haz = 1'b1; s.mul = 1'b1;
    return s;
  endfunction

  function automatic exp_t e(input logic st, input logic is, input logic [31:0] p, input logic bz);
    exp_t x;
    x.stall = st; x.issue = is; x.pend = p; x.busy = bz;
    return x;
  endfunction

  function automatic logic [31:0] b(input int r);
    return 32'd1 << r;
  endfunction

  task automatic apply(input in_t s);
    id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_reg_write = s.rw;
    id_is_hazard_0 = s.haz; id_is_multiply = s.mul; ex_ready = s.rdy; flush = s.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t got;
    rstn = 1'b0;
    @(negedge clk);
    apply(f_alu(6, 5, 4));
    sb.push_back(e(1'b0, 1'b1, 32'd0, 1'b0));
    tick();
    #1;
    got = sb.pop_front(); checks++;
    if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
      failures++;
      $display("FAIL reset_active stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
               stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    apply(f_alu(6, 5, 4));
    sb.push_back(e(1'b0, 1'b1, 32'd0, 1'b0));
    #1;
    got = sb.pop_front(); checks++;
    if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
      failures++;
      $display("FAIL reset_release stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
               stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
    end
    tick();
  endtask

  task automatic test_load_use();
    in_t s[4]; exp_t x[4]; exp_t got;
    s[0] = f_ld(5, 1);     x[0] = e(0, 1, 32'd0, 0);
    s[1] = f_alu(6, 5, 0); x[1] = e(1, 0, b(5), 0);
    s[2] = f_alu(6, 5, 0); x[2] = e(0, 1, 32'd0, 0);
    s[3] = f_nop();        x[3] = e(0, 0, 32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); sb.push_back(x[i]); #1;
      got = sb.pop_front(); checks++;
      if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
        failures++;
        $display("FAIL load_use c%0d stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
      end
      tick();
    end
  endtask

  task automatic test_mul_raw();
    in_t s[6]; exp_t x[6]; exp_t got;
    s[0] = f_mul(7, 1, 2); x[0] = e(0, 1, 32'd0, 0);
    s[1] = f_alu(8, 7, 0); x[1] = e(1, 0, b(7), 1);
    s[2] = f_alu(8, 7, 0); x[2] = e(1, 0, b(7), 1);
    s[3] = f_alu(8, 0, 7); x[3] = e(1, 0, b(7), 1);
    s[4] = f_alu(8, 7, 0); x[4] = e(0, 1, 32'd0, 0);
    s[5] = f_nop();        x[5] = e(0, 0, 32'd0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); sb.push_back(x[i]); #1;
      got = sb.pop_front(); checks++;
      if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
        failures++;
        $display("FAIL mul_raw c%0d stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
      end
      tick();
    end
  endtask

  task automatic test_struct();
    in_t s[9]; exp_t x[9]; exp_t got;
    for (int i = 0; i < 9; i++) s[i] = f_nop();
    s[0] = f_mul(10, 1, 2);
`ifdef ISSUE_MUL_PIPELINED_EN
    s[1] = f_mul(11, 3, 4);
    x[0] = e(0, 1, 32'd0, 0);
    x[1] = e(0, 1, b(10), 0);
    x[2] = e(0, 0, b(10) | b(11), 0);
    x[3] = e(0, 0, b(10) | b(11), 0);
    x[4] = e(0, 0, b(11), 0);
    for (int i = 5; i < 9; i++) x[i] = e(0, 0, 32'd0, 0);
`else
    for (int i = 1; i < 5; i++) s[i] = f_mul(11, 3, 4);
    x[0] = e(0, 1, 32'd0, 0);
    x[1] = e(1, 0, b(10), 1);
    x[2] = e(1, 0, b(10), 1);
    x[3] = e(1, 0, b(10), 1);
    x[4] = e(0, 1, 32'd0, 0);
    x[5] = e(0, 0, b(11), 1);
    x[6] = e(0, 0, b(11), 1);
    x[7] = e(0, 0, b(11), 1);
    x[8] = e(0, 0, 32'd0, 0);
`endif
    for (int i = 0; i < 9; i++) begin
      apply(s[i]); sb.push_back(x[i]); #1;
      got = sb.pop_front(); checks++;
      if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
        failures++;
        $display("FAIL struct c%0d stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
      end
      tick();
    end
  endtask

  task automatic test_freeze_flush_x0();
    in_t s[11]; exp_t x[11]; exp_t got;
    s[0]  = f_ld(5, 1);     x[0]  = e(0, 1, 32'd0, 0);
    s[1]  = f_alu(6, 5, 0); s[1].rdy = 1'b0; x[1] = e(1, 0, b(5), 0);
    s[2]  = f_alu(6, 5, 0); s[2].rdy = 1'b0; x[2] = e(1, 0, b(5), 0);
    s[3]  = f_alu(6, 5, 0); x[3]  = e(1, 0, b(5), 0);
    s[4]  = f_alu(6, 5, 0); x[4]  = e(0, 1, 32'd0, 0);
    s[5]  = f_ld(5, 1);     x[5]  = e(0, 1, 32'd0, 0);
    s[6]  = f_alu(6, 5, 0); s[6].fl = 1'b1; x[6] = e(0, 0, b(5), 0);
    s[7]  = f_nop();        x[7]  = e(0, 0, 32'd0, 0);
    s[8]  = f_ld(0, 1);     x[8]  = e(0, 1, 32'd0, 0);
    s[9]  = f_alu(6, 0, 0); x[9]  = e(0, 1, 32'd0, 0);
    s[10] = f_nop();        x[10] = e(0, 0, 32'd0, 0);
    for (int i = 0; i < 11; i++) begin
      apply(s[i]); sb.push_back(x[i]); #1;
      got = sb.pop_front(); checks++;
      if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
        failures++;
        $display("FAIL freeze_flush_x0 c%0d stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
      end
      tick();
    end
  endtask

  task automatic test_waw();
    in_t s[10]; exp_t x[10]; exp_t got;
    s[0] = f_mul(9, 1, 2);   x[0] = e(0, 1, 32'd0, 0);
    s[1] = f_ld(9, 1);       x[1] = e(1, 0, b(9), 1);
    s[2] = f_ld(9, 1);       x[2] = e(1, 0, b(9), 1);
    s[3] = f_ld(9, 1);       x[3] = e(0, 1, b(9), 1);
    s[4] = f_nop();          x[4] = e(0, 0, b(9), 0);
    s[5] = f_nop();          x[5] = e(0, 0, 32'd0, 0);
    s[6] = f_ld(12, 1);      x[6] = e(0, 1, 32'd0, 0);
    s[7] = f_alu(12, 1, 2);  x[7] = e(1, 0, b(12), 0);
    s[8] = f_alu(12, 1, 2);  x[8] = e(0, 1, 32'd0, 0);
    s[9] = f_nop();          x[9] = e(0, 0, 32'd0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(s[i]); sb.push_back(x[i]); #1;
      got = sb.pop_front(); checks++;
      if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
        failures++;
        $display("FAIL waw c%0d stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    in_t s[5]; exp_t x[5]; exp_t got;
    s[0] = f_ld(5, 1);     x[0] = e(0, 1, 32'd0, 0);
    s[1] = f_ld(6, 1);     x[1] = e(0, 1, b(5), 0);
    s[2] = f_alu(7, 5, 6); x[2] = e(1, 0, b(6), 0);
    s[3] = f_alu(7, 5, 6); x[3] = e(0, 1, 32'd0, 0);
    s[4] = f_nop();        x[4] = e(0, 0, 32'd0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); sb.push_back(x[i]); #1;
      got = sb.pop_front(); checks++;
      if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
        failures++;
        $display("FAIL back_to_back c%0d stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    exp_t got;
    apply(f_mul(13, 1, 2));
    tick();
    apply(f_nop());
    sb.push_back(e(1'b0, 1'b0, b(13), 1'b1));
    `ifdef ISSUE_MUL_PIPELINED_EN
    sb[0].busy = 1'b0;
    `endif
    #1;
    got = sb.pop_front(); checks++;
    if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
      failures++;
      $display("FAIL async_reset_pre stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
               stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
    end
    rstn = 1'b0;
    sb.push_back(e(1'b0, 1'b0, 32'd0, 1'b0));
    #1;
    got = sb.pop_front(); checks++;
    if ({stall, issue, pending, mul_busy} !== {got.stall, got.issue, got.pend, got.busy}) begin
      failures++;
      $display("FAIL async_reset_clear stall/issue/pending/busy: got %b/%b/%h/%b want %b/%b/%h/%b",
               stall, issue, pending, mul_busy, got.stall, got.issue, got.pend, got.busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    apply(f_nop());
    test_reset();
    test_load_use();
    test_mul_raw();
    test_struct();
    test_freeze_flush_x0();
    test_waw();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
